alu_share_arbiter: RTL and testbench

Arbitrates one shared combinational ALU between two requesters, for example the main execute path and a branch/address helper. Each requester issues an operation over a valid/ready handshake. The block grants access round-robin, drives the ALU from registered operands, and captures result, zero and overflow flags into a response register held under rsp_valid/rsp_ready backpressure. It also keeps a saturating overflow counter for debug.

---
 rtl/alu_share_arbiter.sv | 116 +++++++++++
 tb/tb_alu_share_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one combinational ALU
// between two requesters, with a registered response and a saturating overflow count.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_src1_i,
  input  logic [DATA_W-1:0] req0_src2_i,
  input  logic [CTRL_W-1:0] req0_ctrl_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_src1_i,
  input  logic [DATA_W-1:0] req1_src2_i,
  input  logic [CTRL_W-1:0] req1_ctrl_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  output logic              rsp_err_o,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  input  logic              alu_err_i,
  output logic              busy_o,
  output logic [7:0]        err_count_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   src1_q, src2_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic                id_q;
  logic                last_grant_q;
  logic [DATA_W-1:0]   rsp_result_q;
  logic                rsp_zero_q, rsp_err_q, rsp_id_q;
  logic [7:0]          err_count_q, err_count_d;
  logic                window, grant1, accept, ctrl_legal, exec;

  assign exec       = (state_q == EXEC);
  assign ctrl_legal = (ctrl_q != '0) && (ctrl_q <= CTRL_W'(17));

  always_comb begin
    window = 1'b0;
    grant1 = 1'b0;
    accept = 1'b0;
    state_d = state_q;
    err_count_d = err_count_q;
    // Reset gates the accept window so nothing is acknowledged in a reset cycle.
    window = !rst_i && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready_i));
    grant1 = req1_valid_i && (!req0_valid_i || !last_grant_q);
    req0_ready_o = window && req0_valid_i && !grant1;
    req1_ready_o = window && grant1;
    accept = req0_ready_o || req1_ready_o;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
    if (exec && ctrl_legal && alu_err_i && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      src1_q       <= '0;
      src2_q       <= '0;
      ctrl_q       <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      err_count_q <= err_count_d;
      if (accept) begin
        src1_q       <= grant1 ? req1_src1_i : req0_src1_i;
        src2_q       <= grant1 ? req1_src2_i : req0_src2_i;
        ctrl_q       <= grant1 ? req1_ctrl_i : req0_ctrl_i;
        id_q         <= grant1;
        last_grant_q <= grant1;
      end
      if (exec) begin
        rsp_result_q <= ctrl_legal ? alu_result_i : '0;
        rsp_zero_q   <= ctrl_legal && alu_zero_i;
        rsp_err_q    <= ctrl_legal && alu_err_i;
        rsp_id_q     <= id_q;
      end
    end
  end

  // ALU inputs come only from registers so no request path reaches the ALU.
  assign alu_src1_o   = exec ? src1_q : '0;
  assign alu_src2_o   = exec ? src2_q : '0;
  assign alu_ctrl_o   = (exec && ctrl_legal) ? ctrl_q : '0;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp_err_o    = rsp_err_q;
  assign busy_o       = (state_q != IDLE);
  assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed vector bench for alu_share_arbiter
// with a small stand-in ALU.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0] r0_s1, r0_s2, r1_s1, r1_s2;
  logic [4:0]  r0_ctrl, r1_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic [31:0] rsp_result, alu_s1, alu_s2, alu_res;
  logic [4:0]  alu_ctrl;
  logic        alu_zero, alu_err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(5)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(r0_valid), .req0_ready_o(r0_ready),
    .req0_src1_i(r0_s1), .req0_src2_i(r0_s2), .req0_ctrl_i(r0_ctrl),
    .req1_valid_i(r1_valid), .req1_ready_o(r1_ready),
    .req1_src1_i(r1_s1), .req1_src2_i(r1_s2), .req1_ctrl_i(r1_ctrl),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err),
    .alu_src1_o(alu_s1), .alu_src2_o(alu_s2), .alu_ctrl_o(alu_ctrl),
    .alu_result_i(alu_res), .alu_zero_i(alu_zero), .alu_err_i(alu_err),
    .busy_o(busy), .err_count_o(err_count)
  );

  // Stand-in ALU: unknown codes return junk so the forced-zero capture is visible.
  always_comb begin
    alu_res  = 32'hDEADBEEF;
    alu_zero = 1'b1;
    alu_err  = 1'b1;
    case (alu_ctrl)
      5'b00001: begin
        alu_res  = alu_s1 + alu_s2;
        alu_zero = (alu_res == 0);
        alu_err  = (alu_s1[31] == alu_s2[31]) && (alu_res[31] != alu_s1[31]);
      end
      5'b00010: begin
        alu_res  = alu_s1 - alu_s2;
        alu_zero = (alu_res == 0);
        alu_err  = (alu_s1[31] != alu_s2[31]) && (alu_res[31] != alu_s1[31]);
      end
      5'b00100: begin
        alu_res = alu_s1 | alu_s2; alu_zero = (alu_res == 0); alu_err = 1'b0;
      end
      5'b01101: begin
        alu_res = 32'd0; alu_zero = (alu_s1 == alu_s2); alu_err = 1'b0;
      end
      5'b10001: begin
        alu_res = alu_s1 & alu_s2; alu_zero = (alu_res == 0); alu_err = 1'b0;
      end
      default: ;
    endcase
  end

  typedef struct {
    logic        id;
    logic [4:0]  ctrl;
    logic [31:0] s1, s2, res;
    logic        z, e;
  } vec_t;

  vec_t tbl[9];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   errc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input vec_t v);
    logic legal;
    legal = (v.ctrl != 5'd0) && (v.ctrl <= 5'd17);
    rsp_ready = 1'b1;
    if (v.id) begin
      r1_valid = 1'b1; r1_s1 = v.s1; r1_s2 = v.s2; r1_ctrl = v.ctrl;
    end else begin
      r0_valid = 1'b1; r0_s1 = v.s1; r0_s2 = v.s2; r0_ctrl = v.ctrl;
    end
    #1;
    chk("ready_owner", v.id ? r1_ready : r0_ready, 1);
    chk("ready_other", v.id ? r0_ready : r1_ready, 0);
    cyc();
    r0_valid = 1'b0; r1_valid = 1'b0;
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_alu_ctrl", alu_ctrl, legal ? v.ctrl : 5'd0);
    chk("exec_alu_src1", alu_s1, v.s1);
    cyc();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_result", rsp_result, v.res);
    chk("rsp_zero", rsp_zero, v.z);
    chk("rsp_err", rsp_err, v.e);
    chk("rsp_id", rsp_id, v.id);
    if (v.e && errc < 255) errc++;
    chk("err_count", err_count, errc);
    cyc();
    chk("back_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t ov;
    tbl[0] = '{1'b0, 5'b00001, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 5'b00010, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 5'b00100, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 5'b00001, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 5'b11111, 32'd5, 32'd3, 32'd0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 5'b01101, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 5'b10010, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 5'b10001, 32'hFF, 32'h0F, 32'h0F, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 5'b00010, 32'd4, 32'd4, 32'd0, 1'b1, 1'b0};

    rst = 1'b1; rsp_ready = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_s1 = 0; r0_s2 = 0; r0_ctrl = 5'b00001;
    r1_s1 = 0; r1_s2 = 0; r1_ctrl = 5'b00001;
    cyc(); cyc();
    chk("rst_ready0", r0_ready, 0);
    chk("rst_ready1", r1_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_alu_src1", alu_s1, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
    cyc();

    for (int i = 0; i < 9; i++) run_op(tbl[i]);

    ov = tbl[3];
    for (int i = 0; i < 300; i++) run_op(ov);
    chk("err_count_sat", err_count, 255);

    // Backpressure: response held, pending req0 blocked until release.
    r0_valid = 1'b1; r0_s1 = 1; r0_s2 = 2; r0_ctrl = 5'b00001; rsp_ready = 1'b1;
    cyc();
    r0_s1 = 20; r0_s2 = 22;
    cyc();
    rsp_ready = 1'b0;
    #1;
    chk("bp_ready_blocked", r0_ready, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_result", rsp_result, 3);
      chk("bp_ready_held", r0_ready, 0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", r0_ready, 1);
    cyc();
    r0_valid = 1'b0;
    #1;
    chk("bp_exec_busy", busy, 1);
    chk("bp_exec_rsp_valid", rsp_valid, 0);
    cyc();
    chk("bp_second_result", rsp_result, 42);
    cyc();

    // Reset during EXEC drops the op; no response must appear afterwards.
    r1_valid = 1'b1; r1_s1 = 1; r1_s2 = 1; r1_ctrl = 5'b00001;
    cyc();
    chk("mid_exec_busy", busy, 1);
    rst = 1'b1; r0_valid = 1'b1;
    cyc();
    #1;
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready0", r0_ready, 0);
    chk("rst_mid_ready1", r1_ready, 0);
    rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; errc = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("no_dropped_rsp", rsp_valid, 0);
    end

    // Round-robin with both valid: grants 0,1,0,1, one accept every 2 cycles.
    r0_valid = 1'b1; r0_s1 = 10; r0_s2 = 3; r0_ctrl = 5'b00010;
    r1_valid = 1'b1; r1_s1 = 32'hF0; r1_s2 = 32'h0F; r1_ctrl = 5'b00100;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready0", r0_ready, (k % 2 == 0) ? 1 : 0);
      chk("rr_ready1", r1_ready, (k % 2 == 1) ? 1 : 0);
      if (k > 0) begin
        chk("rr_rsp_valid", rsp_valid, 1);
        chk("rr_rsp_id", rsp_id, (k % 2 == 1) ? 0 : 1);
        chk("rr_rsp_result", rsp_result, (k % 2 == 1) ? 32'd7 : 32'hFF);
      end
      cyc();
      #1;
      chk("rr_exec_ready0", r0_ready, 0);
      chk("rr_exec_rsp_valid", rsp_valid, 0);
      cyc();
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk("rr_last_id", rsp_id, 1);
    chk("rr_last_result", rsp_result, 32'hFF);
    chk("rr_err_count", err_count, 0);
    cyc();
    chk("rr_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
